// File: rtl/wdt_pkg.sv
// Shared types and default register offsets for the watchdog control core.
package wdt_pkg;

  // Watchdog sequencing states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    TIMEOUT = 2'd2
  } wdt_state_t;

  // Default byte offsets (addr[11:0]) of the software-visible registers.
  localparam logic [11:0] OFS_WDEN_DEF   = 12'h100;
  localparam logic [11:0] OFS_WDLIVE_DEF = 12'h200;
  localparam logic [11:0] OFS_WTOCNT_DEF = 12'h300;

  // Byte lanes carried by one write beat.
  localparam int unsigned WR_BYTES = 4;

endpackage

// File: rtl/wdt_counter.sv
// Timeout counter: synchronous clear, increment, and an unsigned >= limit flag.
module wdt_counter
  import wdt_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             ge_c
);

  // Clear has priority over increment; callers never increment past limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Expiry flag consumed by the sequencer in the same cycle.
  assign ge_c = (cnt >= limit);

endmodule

// File: rtl/wdt_ctrl.sv
// Watchdog control core: register write decode, timeout sequencer, interrupt.
module wdt_ctrl
  import wdt_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter logic [11:0] OFS_WDEN   = OFS_WDEN_DEF,
  parameter logic [11:0] OFS_WDLIVE = OFS_WDLIVE_DEF,
  parameter logic [11:0] OFS_WTOCNT = OFS_WTOCNT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [31:0]      wr_addr,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_strb,
  output logic             addr_err,
  output logic [CNT_W-1:0] cnt_o,
  output logic             WDT_interrupt
);

  localparam int unsigned WIDE_W = (CNT_W > 32) ? CNT_W : 32;

  logic             wden;
  logic [CNT_W-1:0] wtocnt;
  logic             start_q;
  logic             stop_q;
  logic             kick_q;
  wdt_state_t       state;
  wdt_state_t       state_nxt;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             cnt_ge;
  logic [11:0]      ofs;
  logic             hit_wden;
  logic             hit_live;
  logic             hit_wtocnt;
  logic [WIDE_W-1:0] wtocnt_wide;
  logic             unused_addr;

  assign ofs         = wr_addr[11:0];
  assign hit_wden    = (ofs == OFS_WDEN);
  assign hit_live    = (ofs == OFS_WDLIVE);
  assign hit_wtocnt  = (ofs == OFS_WTOCNT);
  assign unused_addr = ^wr_addr[31:12];

  // Byte-lane merge of a WTOCNT write over the current value.
  always_comb begin
    wtocnt_wide = WIDE_W'(wtocnt);
    for (int i = 0; i < WR_BYTES; i++) begin
      if (wr_strb[i]) begin
        wtocnt_wide[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  // Register decode; enable edges and kicks become one-cycle event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wden     <= 1'b0;
      wtocnt   <= '0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      kick_q   <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      kick_q   <= 1'b0;
      addr_err <= 1'b0;
      if (wr_en) begin
        if (hit_wden) begin
          if (wr_strb[0]) begin
            wden    <= wr_data[0];
            start_q <= !wden && wr_data[0];
            stop_q  <= wden && !wr_data[0];
          end
        end else if (hit_live) begin
          kick_q <= wr_strb[0] && wr_data[0];
        end else if (hit_wtocnt) begin
          wtocnt <= CNT_W'(wtocnt_wide);
        end else begin
          addr_err <= 1'b1;
        end
      end
    end
  end

  // Next state and counter control: wden clear > kick > expiry > increment.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (start_q) begin
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        if (stop_q) begin
          state_nxt = IDLE;
          cnt_clr   = 1'b1;
        end else if (kick_q) begin
          cnt_clr = 1'b1;
        end else if (cnt_ge) begin
          state_nxt = TIMEOUT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      TIMEOUT: begin
        if (stop_q) begin
          state_nxt = IDLE;
          cnt_clr   = 1'b1;
        end else if (kick_q) begin
          state_nxt = COUNT;
          cnt_clr   = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_clr   = 1'b1;
      end
    endcase
  end

  // State register; the interrupt is registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      WDT_interrupt <= 1'b0;
    end else begin
      state         <= state_nxt;
      WDT_interrupt <= (state_nxt == TIMEOUT);
    end
  end

  wdt_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .limit (wtocnt),
    .cnt   (cnt_o),
    .ge_c  (cnt_ge)
  );

endmodule

// File: doc/wdt_ctrl.md
# wdt_ctrl

Watchdog timer control core behind the write-only AXI slave of the WDT wrapper. It decodes single-beat register writes (WDEN, WDLIVE, WTOCNT) coming out of the slave, sequences a 32-bit timeout counter, and raises a level `WDT_interrupt` to the CPU when software fails to kick the watchdog in time. It has one clock domain; clock-domain crossing to the CPU side lives outside this block.

## Interface
- `CNT_W`, default 32: counter and WTOCNT width.
- `OFS_WDEN`, default 12'h100: byte-offset (addr[11:0]) of WDEN.
- `OFS_WDLIVE`, default 12'h200: byte-offset of WDLIVE.
- `OFS_WTOCNT`, default 12'h300: byte-offset of WTOCNT.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: one-cycle write strobe from the AXI slave; always accepted.
- `wr_addr` in 32: write byte address; only [11:0] decoded.
- `wr_data` in 32: write data.
- `wr_strb` in 4: byte strobes, active-high.
- `addr_err` out 1: one-cycle pulse, write to an unmapped offset (slave maps it to SLVERR).
- `cnt_o` out CNT_W: current counter value (debug/status).
- `WDT_interrupt` out 1: timeout interrupt, level, registered.

## Operation
- Registers: `wden` (1 bit), `wtocnt` (CNT_W), `cnt` (CNT_W), FSM state. WDLIVE is not stored; a write is a kick pulse.
- Write decode (when `wr_en`=1):
  - WDEN: if wr_strb[0], set wden to wr_data[0].
  - WDLIVE: if wr_strb[0] and wr_data[0], raise kick.
  - WTOCNT: each byte i with wr_strb[i] set updates wtocnt[8i+7:8i]. The new value is used from the next cycle, including mid-count.
  - Any other offset: no register change; addr_err=1 the next cycle.
- FSM states: IDLE, COUNT, TIMEOUT.
  - IDLE: cnt=0. Go to COUNT when a WDEN write sets wden 0->1.
  - COUNT: if cnt >= wtocnt, go to TIMEOUT with cnt held; else cnt <= cnt+1. A kick sets cnt <= 0 and stays in COUNT.
  - TIMEOUT: cnt held. A kick sets cnt <= 0 and goes to COUNT.
  - From COUNT or TIMEOUT: a write clearing wden goes to IDLE with cnt <= 0.
- Priority for simultaneous events: rst > wden clear > kick > timeout compare > increment.
- Arithmetic: the compare is unsigned. The increment never wraps, because the compare blocks it at wtocnt ≤ 2^CNT_W−1.
- Kick or WDEN write while already in the target condition: a kick in IDLE is ignored, and writing wden=1 while already 1 is ignored (no restart).

## Timing
- Reset values: state=IDLE, wden=0, wtocnt=0, cnt=0, cnt_o=0, WDT_interrupt=0, addr_err=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `WDT_interrupt` = (state==TIMEOUT), registered.
- With wtocnt=N, a WDEN=1 write at edge 0 gives state COUNT with cnt=0 after edge 1.
  - cnt=N after edge 1+N.
  - WDT_interrupt=1 after edge 2+N.
- Kick on edge k: cnt=0 after edge k+1. If the block was in TIMEOUT, WDT_interrupt falls after edge k+1.
- WDEN clear on edge k: WDT_interrupt=0 and cnt=0 after edge k+1.
- A reset mid-count or during TIMEOUT returns all state to reset values on that edge; the interrupt drops immediately.
- Back-to-back writes on consecutive cycles are all applied in order.

## Structure
- `wdt_pkg` holds the state enum `wdt_state_t` {IDLE, COUNT, TIMEOUT} and the default offset localparams.
- One sub-module, `wdt_counter`: CNT_W counter with clr, inc, and a `>=` compare flag. The FSM and register decode stay in `wdt_ctrl`.

## Test plan
- Reset, then wtocnt=5, then WDEN=1: WDT_interrupt rises exactly 7 cycles after the WDEN write edge, with cnt_o=5.
- Same setup, kick every 4 cycles for 40 cycles: WDT_interrupt stays 0 and cnt_o never exceeds 4.
- In TIMEOUT, write WDLIVE=1: interrupt falls next cycle, cnt_o=0, then times out again after 7 cycles.
- Kick and WDEN=0 on adjacent cycles near timeout (cnt=wtocnt): WDEN clear wins; state IDLE, interrupt 0, cnt_o 0.
- Byte-strobe write of WTOCNT=0x0000_00FF with wr_strb=4'b0001 over 0x1234_5600: wtocnt=0x1234_56FF. Write to offset 0x104: addr_err pulses one cycle and no register changes.
- Assert rst during COUNT at cnt=3: next cycle all outputs are at reset values, and a WDEN write restarts from cnt=0.
